switch_input: RTL and testbench

Memory-mapped input peripheral for the board's DIP switches and push keys; the read-side counterpart of the LED output device on the same CPU peripheral bus. Raw active-low pins are synchronised, debounced and presented to the CPU as inverted levels (1 = on/pressed). Key presses set sticky pending flags, cleared by writing 1, and raise a maskable interrupt line for the CPU's interrupt controller.

---
 rtl/switch_input_pkg.sv | 16 +
 rtl/switch_input_debouncer.sv | 51 +++++
 rtl/switch_input.sv | 76 +++++++
 tb/tb_switch_input.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/switch_input_pkg.sv
// Shared definitions for the switch/key input peripheral: register map,
// pin counts and the released-pin reset pattern.
package switch_input_pkg;

  typedef enum logic [1:0] {
    ADDR_SWITCH = 2'd0,
    ADDR_KEY    = 2'd1,
    ADDR_PEND   = 2'd2,
    ADDR_CTRL   = 2'd3
  } reg_addr_e;

  localparam int          SWITCH_COUNT  = 32;
  localparam int          KEY_COUNT     = 8;
  localparam logic [31:0] PINS_RELEASED = '1;

endpackage

// File: rtl/switch_input_debouncer.sv
// Two-flop synchroniser plus group debouncer: one shared counter per group,
// a new level is accepted after DEBOUNCE_CYCLES consecutive stable cycles.
module input_debouncer
  import switch_input_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] deb,
  output logic [WIDTH-1:0] fall
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RELEASED = WIDTH'(PINS_RELEASED);

  logic [WIDTH-1:0] sync1, sync2, cand;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             accept;

  assign stable = (sync2 == cand);
  assign accept = stable && (cnt == CNT_LAST);
  // Bits that go 1->0 in deb on the coming edge, so the caller can act on the same edge.
  assign fall   = {WIDTH{accept}} & deb & ~cand;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
      cand  <= RELEASED;
      deb   <= RELEASED;
      cnt   <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      if (!stable) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_input.sv
// Memory-mapped DIP switch / push key input device with sticky key-press
// pending flags (write-1-to-clear) and a maskable level interrupt.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] switches,
  input  logic [7:0]  keys,
  input  logic [1:0]  SW_Addr,
  input  logic        SW_We,
  input  logic [31:0] SW_WD,
  output logic [31:0] SW_RD,
  output logic        IRQ
);

  logic [SWITCH_COUNT-1:0] deb_sw, sw_fall_unused;
  logic [KEY_COUNT-1:0]    deb_key, key_fall, pend, en, clr;
  logic [31:KEY_COUNT]     wd_hi_unused;
  reg_addr_e               addr;
  logic                    pend_wr, ctrl_wr;

  input_debouncer #(
    .WIDTH          (SWITCH_COUNT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_deb (
    .clk  (clk),
    .reset(reset),
    .pins (switches),
    .deb  (deb_sw),
    .fall (sw_fall_unused)
  );

  input_debouncer #(
    .WIDTH          (KEY_COUNT),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_deb (
    .clk  (clk),
    .reset(reset),
    .pins (keys),
    .deb  (deb_key),
    .fall (key_fall)
  );

  assign addr         = reg_addr_e'(SW_Addr);
  assign pend_wr      = SW_We && (addr == ADDR_PEND);
  assign ctrl_wr      = SW_We && (addr == ADDR_CTRL);
  assign clr          = pend_wr ? SW_WD[KEY_COUNT-1:0] : '0;
  assign wd_hi_unused = SW_WD[31:KEY_COUNT];

  // Press edge is OR-ed after the clear so a same-edge press survives the W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
      en   <= '0;
    end else begin
      pend <= (pend & ~clr) | key_fall;
      if (ctrl_wr) en <= SW_WD[KEY_COUNT-1:0];
    end
  end

  always_comb begin
    SW_RD = '0;
    case (addr)
      ADDR_SWITCH: SW_RD = ~deb_sw;
      ADDR_KEY:    SW_RD = {{(32-KEY_COUNT){1'b0}}, ~deb_key};
      ADDR_PEND:   SW_RD = {{(32-KEY_COUNT){1'b0}}, pend};
      ADDR_CTRL:   SW_RD = {{(32-KEY_COUNT){1'b0}}, en};
    endcase
  end

  assign IRQ = |(pend & en);

endmodule

// File: tb/tb_switch_input.sv
// Self-checking bench for switch_input with DEBOUNCE_CYCLES=4: table-driven
// per-cycle vectors, hand sequences for reset and W1C/press collision.
module tb_switch_input;

  localparam logic [31:0] SWV = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] switches;
  logic [7:0]  keys;
  logic [1:0]  SW_Addr;
  logic        SW_We;
  logic [31:0] SW_WD;
  logic [31:0] SW_RD;
  logic        IRQ;

  always #5 clk = ~clk;

  switch_input #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .switches(switches),
    .keys    (keys),
    .SW_Addr (SW_Addr),
    .SW_We   (SW_We),
    .SW_WD   (SW_WD),
    .SW_RD   (SW_RD),
    .IRQ     (IRQ)
  );

  typedef struct {
    logic [31:0] sw;
    logic [7:0]  key;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wd;
    logic [1:0]  raddr;
    logic [31:0] rd;
    logic        irq;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic [31:0] sw, input logic [7:0] key, input logic we,
                     input logic [1:0] waddr, input logic [31:0] wd, input logic [1:0] raddr,
                     input logic [31:0] rd, input logic irq, input string name);
    vec_t v;
    v = '{sw, key, we, waddr, wd, raddr, rd, irq, name};
    vecs.push_back(v);
  endtask

  task automatic compare_out();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued, SW_RD=%h IRQ=%b", SW_RD, IRQ);
      return;
    end
    e = exp_q.pop_front();
    if (SW_RD !== e.rd || IRQ !== e.irq) begin
      errors++;
      $display("FAIL %s: SW_RD=%h IRQ=%b, expected SW_RD=%h IRQ=%b",
               e.name, SW_RD, IRQ, e.rd, e.irq);
    end
  endtask

  // One vector = one posedge: drive at negedge, read back just after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    switches = v.sw;
    keys     = v.key;
    SW_We    = v.we;
    SW_Addr  = v.waddr;
    SW_WD    = v.wd;
    e = '{v.rd, v.irq, v.name};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    SW_We   = 1'b0;
    SW_Addr = v.raddr;
    #1;
    compare_out();
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] sw, input logic [7:0] key, input logic we,
                     input logic [1:0] waddr, input logic [31:0] wd, input logic [1:0] raddr,
                     input logic [31:0] rd, input logic irq, input string name);
    vec_t v;
    v = '{sw, key, we, waddr, wd, raddr, rd, irq, name};
    step(v);
  endtask

  task automatic check_read(input logic [1:0] a, input logic [31:0] rd,
                            input logic irq, input string name);
    exp_t e;
    SW_Addr = a;
    e = '{rd, irq, name};
    exp_q.push_back(e);
    #1;
    compare_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: debounce, key toggling, enable/IRQ and release behaviour.
    for (int i = 0; i < 8; i++)
      add(SWV, 8'hFF, 1'b0, 2'd0, 32'h0, 2'd0, (i >= 6) ? 32'h0000_00FF : 32'h0, 1'b0, "switch_debounce");
    for (int c = 0; c < 10; c++)
      add(SWV, ((c / 2) % 2 == 0) ? 8'hFF : 8'hFE, 1'b0, 2'd0, 32'h0, 2'd1, 32'h0, 1'b0, "key_toggle");
    for (int c = 0; c < 7; c++)
      add(SWV, 8'hFE, 1'b0, 2'd0, 32'h0, 2'd1, (c == 6) ? 32'h1 : 32'h0, 1'b0, "key_settle");
    add(SWV, 8'hFE, 1'b0, 2'd0, 32'h0, 2'd2, 32'h1, 1'b0, "pend_once");
    add(SWV, 8'hFE, 1'b1, 2'd2, 32'h1, 2'd2, 32'h0, 1'b0, "pend_w1c");
    add(SWV, 8'hFE, 1'b1, 2'd3, 32'hFFFF_FF01, 2'd3, 32'h1, 1'b0, "ctrl_write");
    for (int c = 0; c < 7; c++)
      add(SWV, 8'hFF, 1'b0, 2'd0, 32'h0, 2'd1, (c == 6) ? 32'h0 : 32'h1, 1'b0, "key0_release");
    add(SWV, 8'hFF, 1'b0, 2'd0, 32'h0, 2'd2, 32'h0, 1'b0, "no_pend_on_release");
    for (int c = 0; c < 7; c++)
      add(SWV, 8'hFE, 1'b0, 2'd0, 32'h0, 2'd2, (c == 6) ? 32'h1 : 32'h0, c == 6, "key0_press_irq");
    add(SWV, 8'hFE, 1'b1, 2'd2, 32'h1, 2'd2, 32'h0, 1'b0, "w1c_drops_irq");
    for (int c = 0; c < 7; c++)
      add(SWV, 8'hFC, 1'b0, 2'd0, 32'h0, 2'd2, (c == 6) ? 32'h2 : 32'h0, 1'b0, "key1_masked");

    reset    = 1'b0;
    switches = '1;
    keys     = '1;
    SW_Addr  = 2'd0;
    SW_We    = 1'b0;
    SW_WD    = '0;
    repeat (2) @(negedge clk);

    // Reset asserted mid-count, then full debounce from release.
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      run(32'h0, 8'hFF, 1'b0, 2'd0, 32'h0, 2'd0, 32'h0, 1'b0, "pre_reset_count");
    reset = 1'b0;
    #1;
    for (int a = 0; a < 4; a++)
      check_read(2'(a), 32'h0, 1'b0, "in_reset_read");
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++)
      run(32'h0, 8'hFF, 1'b0, 2'd0, 32'h0, 2'd0, (e == 7) ? 32'hFFFF_FFFF : 32'h0, 1'b0, "switch_after_reset");

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) step(vecs[i]);

    // Key2 press edge coincides with a W1C of bit 2: the set must win.
    for (int c = 0; c < 6; c++)
      run(SWV, 8'hF8, 1'b0, 2'd0, 32'h0, 2'd2, 32'h2, 1'b0, "key2_pending");
    run(SWV, 8'hF8, 1'b1, 2'd2, 32'h4, 2'd2, 32'h6, 1'b0, "set_beats_w1c");
    run(SWV, 8'hF8, 1'b1, 2'd2, 32'h4, 2'd2, 32'h2, 1'b0, "w1c_bit2");
    run(SWV, 8'hF8, 1'b1, 2'd2, 32'hFF, 2'd2, 32'h0, 1'b0, "w1c_all");

    // Release key1, then confirm SWITCH/KEY ignore writes.
    for (int c = 0; c < 7; c++)
      run(SWV, 8'hFA, 1'b0, 2'd0, 32'h0, 2'd1, (c == 6) ? 32'h5 : 32'h7, 1'b0, "key1_release");
    run(SWV, 8'hFA, 1'b0, 2'd0, 32'h0, 2'd2, 32'h0, 1'b0, "release_no_pend");
    run(SWV, 8'hFA, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_00FF, 1'b0, "switch_read_only");
    run(SWV, 8'hFA, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h5, 1'b0, "key_read_only");
    run(SWV, 8'hFA, 1'b0, 2'd0, 32'h0, 2'd2, 32'h0, 1'b0, "pend_after_ro");
    run(SWV, 8'hFA, 1'b0, 2'd0, 32'h0, 2'd3, 32'h1, 1'b0, "ctrl_after_ro");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
